// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the fetch/decode PC unit.
// Holds the next-PC select encodings, the branch-type codes used by the
// D-stage comparator, and the branch target helper.
package branch_pc_unit_pkg;

  // Next-PC select codes driven by the D-stage decoder
  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_B   = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  // Branch-type codes consumed by the D-stage comparator producing Bflag
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_e;

  // PC-relative branch target: the offset is relative to the delay slot
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm16);
    return pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/branch_pc_unit_npc_sel.sv
// Combinational next-PC selection.
// Ports:
//   f_pc_i      current fetch address
//   d_pc_i      PC of the instruction in D
//   d_idx_i     D_instr[25:0] (jump index; low 16 bits are the branch offset)
//   op_npc_i    next-PC select
//   bflag_i     branch condition result
//   ra_i        register target for jr/jalr
//   next_pc_o   selected next fetch address
//   taken_o     a redirect (taken branch, j, jr) is selected
module branch_pc_unit_npc_sel
  import branch_pc_unit_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic [25:0] d_idx_i,
  input  logic [2:0]  op_npc_i,
  input  logic        bflag_i,
  input  logic [31:0] ra_i,
  output logic [31:0] next_pc_o,
  output logic        taken_o
);

  always_comb begin
    next_pc_o = f_pc_i + 32'd4;
    taken_o   = 1'b0;
    case (op_npc_i)
      NPC_B: begin
        if (bflag_i) begin
          next_pc_o = branch_target(d_pc_i, d_idx_i[15:0]);
          taken_o   = 1'b1;
        end
      end
      NPC_J: begin
        next_pc_o = {d_pc_i[31:28], d_idx_i, 2'b00};
        taken_o   = 1'b1;
      end
      NPC_JR: begin
        next_pc_o = ra_i;
        taken_o   = 1'b1;
      end
      // Unlisted codes fall through as sequential fetch
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC and F/D pipeline register with one architectural delay slot.
// The redirect decided in D only changes the next fetch; the instruction
// already in F always proceeds into D.
// Ports:
//   clk        system clock (rising edge)
//   reset      synchronous active-low reset
//   stall      freezes fetch PC, F/D register and status
//   Bflag      D-stage branch condition
//   opNPC      D-stage next-PC select
//   ra         forwarded rs for jr
//   F_instr    instruction fetched at F_PC
//   F_PC       fetch address
//   D_PC       PC of instruction in D
//   D_instr    instruction in D
//   D_PC8      link address D_PC+8 (combinational)
//   misalign   sticky misaligned-redirect flag
//   taken_cnt  saturating count of taken redirects
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Bflag,
  input  logic [2:0]  opNPC,
  input  logic [31:0] ra,
  input  logic [31:0] F_instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC8,
  output logic        misalign,
  output logic [31:0] taken_cnt
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] next_pc;
  logic        taken;

  branch_pc_unit_npc_sel npc_sel (
    .f_pc_i    (f_pc_q),
    .d_pc_i    (d_pc_q),
    .d_idx_i   (d_instr_q[25:0]),
    .op_npc_i  (opNPC),
    .bflag_i   (Bflag),
    .ra_i      (ra),
    .next_pc_o (next_pc),
    .taken_o   (taken)
  );

  always_comb begin
    f_pc_d      = next_pc;
    d_pc_d      = f_pc_q;
    d_instr_d   = F_instr;
    // Only redirect targets are screened; sequential fetch is not a redirect
    misalign_d  = misalign_q | (taken & (next_pc[1:0] != 2'b00));
    taken_cnt_d = (taken && (taken_cnt_q != 32'hFFFF_FFFF)) ?
                  taken_cnt_q + 32'd1 : taken_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      f_pc_q      <= RESET_PC;
      d_pc_q      <= 32'd0;
      d_instr_q   <= 32'd0;
      misalign_q  <= 1'b0;
      taken_cnt_q <= 32'd0;
    end else if (!stall) begin
      f_pc_q      <= f_pc_d;
      d_pc_q      <= d_pc_d;
      d_instr_q   <= d_instr_d;
      misalign_q  <= misalign_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign F_PC      = f_pc_q;
  assign D_PC      = d_pc_q;
  assign D_instr   = d_instr_q;
  assign D_PC8     = d_pc_q + 32'd8;
  assign misalign  = misalign_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;
  import branch_pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        Bflag;
  logic [2:0]  opNPC;
  logic [31:0] ra;
  logic [31:0] F_instr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [31:0] D_PC8;
  logic        misalign;
  logic [31:0] taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .Bflag     (Bflag),
    .opNPC     (opNPC),
    .ra        (ra),
    .F_instr   (F_instr),
    .F_PC      (F_PC),
    .D_PC      (D_PC),
    .D_instr   (D_instr),
    .D_PC8     (D_PC8),
    .misalign  (misalign),
    .taken_cnt (taken_cnt)
  );

  always #5 clk = ~clk;

  // Small instruction memory: j 0x3100 at 0x3000, beq -2 at 0x3004
  function automatic logic [31:0] imem(input logic [31:0] addr);
    case (addr)
      32'h0000_3000: return 32'h0800_0C40;
      32'h0000_3004: return 32'h1000_FFFE;
      default:       return {16'h2400, addr[15:0]};
    endcase
  endfunction

  assign F_instr = imem(F_PC);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; Bflag = 1'b0; opNPC = NPC_J; ra = 32'd0;

    // Reset overrides stall
    step(); step();
    check("rst_fpc",   F_PC, 32'h0000_3000);
    check("rst_dpc",   D_PC, 32'h0);
    check("rst_dinstr", D_instr, 32'h0);
    check("rst_cnt",   taken_cnt, 32'h0);
    check("rst_mis",   {31'd0, misalign}, 32'h0);
    check("rst_pc8",   D_PC8, 32'h8);

    reset = 1'b1; stall = 1'b0; opNPC = NPC_PC4;
    step();
    check("seq1_fpc", F_PC, 32'h0000_3004);
    check("seq1_dpc", D_PC, 32'h0000_3000);
    check("seq1_pc8", D_PC8, 32'h0000_3008);
    step();
    check("beq_dpc",    D_PC, 32'h0000_3004);
    check("beq_dinstr", D_instr, 32'h1000_FFFE);

    // Taken beq in D: 0x3004 + 4 + (-2 << 2) = 0x3000; slot from 0x3008 still enters D
    opNPC = NPC_B; Bflag = 1'b1;
    step();
    check("beq_fpc",    F_PC, 32'h0000_3000);
    check("slot_dpc",   D_PC, 32'h0000_3008);
    check("slot_instr", D_instr, imem(32'h0000_3008));
    check("beq_cnt",    taken_cnt, 32'd1);

    opNPC = NPC_PC4; Bflag = 1'b0;
    step(); step(); step(); step();
    check("walk_fpc", F_PC, 32'h0000_3010);

    // Untaken branch falls through
    opNPC = NPC_B; Bflag = 1'b0;
    step();
    check("untk_fpc", F_PC, 32'h0000_3014);
    check("untk_cnt", taken_cnt, 32'd1);

    // Unlisted select code with Bflag high acts as sequential
    opNPC = 3'd5; Bflag = 1'b1;
    step();
    check("op5_fpc", F_PC, 32'h0000_3018);
    check("op5_cnt", taken_cnt, 32'd1);
    Bflag = 1'b0;

    // jr held off by stall for three edges
    opNPC = NPC_JR; ra = 32'h0000_3100; stall = 1'b1;
    step();
    check("stl1_fpc", F_PC, 32'h0000_3018);
    step(); step();
    check("stl3_fpc",    F_PC, 32'h0000_3018);
    check("stl3_dpc",    D_PC, 32'h0000_3014);
    check("stl3_dinstr", D_instr, imem(32'h0000_3014));
    check("stl3_cnt",    taken_cnt, 32'd1);
    stall = 1'b0;
    step();
    check("jr_fpc", F_PC, 32'h0000_3100);
    check("jr_dpc", D_PC, 32'h0000_3018);
    check("jr_cnt", taken_cnt, 32'd2);

    // Misaligned jr target is loaded as-is and flags
    ra = 32'h0000_3102;
    step();
    check("mis_fpc", F_PC, 32'h0000_3102);
    check("mis_flag", {31'd0, misalign}, 32'h1);
    check("mis_cnt", taken_cnt, 32'd3);
    opNPC = NPC_PC4;
    step(); step();
    check("mis_fpc2",  F_PC, 32'h0000_310A);
    check("mis_stick", {31'd0, misalign}, 32'h1);

    // Reset during a redirect cancels it and clears status
    reset = 1'b0; stall = 1'b1; opNPC = NPC_J;
    step();
    check("rst2_fpc", F_PC, 32'h0000_3000);
    check("rst2_mis", {31'd0, misalign}, 32'h0);
    check("rst2_cnt", taken_cnt, 32'd0);
    reset = 1'b1; stall = 1'b0; opNPC = NPC_PC4;
    step();
    check("rel_fpc",    F_PC, 32'h0000_3004);
    check("rel_dinstr", D_instr, 32'h0800_0C40);

    // j with index 0xC40 from D_PC 0x3000
    opNPC = NPC_J;
    step();
    check("j_fpc", F_PC, 32'h0000_3100);
    check("j_cnt", taken_cnt, 32'd1);

    // Wrap: jump to the top word, then sequential fetch rolls to 0
    opNPC = NPC_JR; ra = 32'hFFFF_FFFC;
    step();
    check("top_fpc", F_PC, 32'hFFFF_FFFC);
    check("top_mis", {31'd0, misalign}, 32'h0);
    opNPC = NPC_PC4;
    step();
    check("wrap_fpc", F_PC, 32'h0000_0000);
    check("wrap_pc8", D_PC8, 32'h0000_0004);
    check("wrap_cnt", taken_cnt, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
